// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external pipelined
// DW x DW multiplier among NUM_REQ valid/ready requesters. Each issued
// operand pair carries its requester ID down a tag pipe aligned with the
// multiplier latency so the product can be routed back one-hot.
// Optional feature macro: MULT_ARB_STATS_EN (per-requester saturating
// 16-bit accept counters on grant_count; tied to zero when undefined).
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         mul_a,
  output logic [DW-1:0]         mul_b,
  input  logic [2*DW-1:0]       mul_product,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [2*DW-1:0]       rsp_data,
  output logic                  busy,
  output logic [NUM_REQ*16-1:0] grant_count
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic             found;
  logic             accept;
  logic [IDW:0]     cand;
  logic [MUL_LAT-1:0] pipe_valid;
  logic [IDW-1:0]   pipe_id [MUL_LAT];
  logic             drain_done;

  // Draining is finished once nothing remains ahead of the tail stage, so the
  // unit reports idle in the cycle right after the last response leaves.
  assign drain_done = ~|pipe_valid[MUL_LAT-2:0];

  // State register for the enable/drain controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: enable always wins over finishing a drain.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN:   if (enable) state_next = RUN;
               else if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[IDW-1:0];
      end
    end
  end

  assign accept = (state == RUN) && found;

  // Grant and operand steering; operands are forced to zero when nothing issues.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
      mul_a = req_a[int'(grant_id)*DW +: DW];
      mul_b = req_b[int'(grant_id)*DW +: DW];
    end
  end

  // Pointer moves just past the requester that was served; holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else if (accept) rr_ptr <= (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
  end

  // Tag pipe shadows the multiplier stages so the tail lines up with its product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int k = 0; k < MUL_LAT; k++) pipe_id[k] <= '0;
    end else begin
      pipe_valid <= {pipe_valid[MUL_LAT-2:0], accept};
      pipe_id[0] <= grant_id;
      for (int k = 1; k < MUL_LAT; k++) pipe_id[k] <= pipe_id[k-1];
    end
  end

  // Response routing from the tail of the tag pipe.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pipe_valid[MUL_LAT-1]) begin
      rsp_valid[pipe_id[MUL_LAT-1]] = 1'b1;
      rsp_data = mul_product;
    end
  end

  assign busy = (state != IDLE) | (|pipe_valid);

`ifdef MULT_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Per-requester accept counters, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) grant_cnt[k] <= '0;
    end else if (accept && grant_cnt[grant_id] != 16'hFFFF) begin
      grant_cnt[grant_id] <= grant_cnt[grant_id] + 16'd1;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    grant_count = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_count[k*16 +: 16] = grant_cnt[k];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench for mult_share_arbiter with a
// 4-stage behavioural multiplier. Honours MULT_ARB_STATS_EN when defined.
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [63:0] grant_count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_ma;
    logic [7:0]  exp_mb;
    logic [3:0]  exp_rsp;
    logic [15:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .grant_count(grant_count)
  );

  // Behavioural multiplier: product of operands driven in cycle n shows in cycle n+4.
  logic [15:0] mp [MUL_LAT];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_LAT; k++) mp[k] <= '0;
    end else begin
      mp[0] <= 16'(mul_a) * 16'(mul_b);
      for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_product = mp[MUL_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    enable    = en;
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " req_ready"}, 64'(req_ready), 64'h0);
    checkOutput({tag, " mul_a"}, 64'(mul_a), 64'h0);
    checkOutput({tag, " mul_b"}, 64'(mul_b), 64'h0);
    checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'h0);
    checkOutput({tag, " rsp_data"}, 64'(rsp_data), 64'h0);
    checkOutput({tag, " busy"}, 64'(busy), 64'h0);
    checkOutput({tag, " grant_count"}, grant_count, 64'h0);
  endtask

  function automatic void addVec(input logic en, input logic [3:0] valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] exp_ready, input logic [7:0] exp_ma,
                                 input logic [7:0] exp_mb, input logic [3:0] exp_rsp,
                                 input logic [15:0] exp_data, input logic exp_busy);
    vec_t v;
    v.en = en; v.valid = valid; v.a = a; v.b = b;
    v.exp_ready = exp_ready; v.exp_ma = exp_ma; v.exp_mb = exp_mb;
    v.exp_rsp = exp_rsp; v.exp_data = exp_data; v.exp_busy = exp_busy;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] all_a;
    logic [3:0]  t4_rsp  [5];
    logic [15:0] t4_data [5];
    logic        t4_busy [5];
    logic [63:0] exp_gc;

    all_a = {8'd4, 8'd3, 8'd2, 8'd1};

    // Cycle-by-cycle table: single issue, max operands, rotation, lone requester.
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0000, 16'd0, 0);
    addVec(1, 4'b0001, 32'h03, 32'h05, 4'b0001, 8'h03, 8'h05, 4'b0000, 16'd0, 1);
    addVec(1, 4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0100, 8'hFF, 8'hFF, 4'b0000, 16'd0, 1);
    addVec(1, 4'b1000, 32'h02000000, 32'h03000000, 4'b1000, 8'h02, 8'h03, 4'b0000, 16'd0, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0001, 8'd1, 8'hFF, 4'b0000, 16'd0, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0010, 8'd2, 8'hFF, 4'b0001, 16'd15, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0100, 8'd3, 8'hFF, 4'b0100, 16'hFE01, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b1000, 8'd4, 8'hFF, 4'b1000, 16'd6, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0001, 8'd1, 8'hFF, 4'b0001, 16'd255, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0010, 8'd2, 8'hFF, 4'b0010, 16'd510, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b0100, 8'd3, 8'hFF, 4'b0100, 16'd765, 1);
    addVec(1, 4'b1111, all_a, 32'hFFFFFFFF, 4'b1000, 8'd4, 8'hFF, 4'b1000, 16'd1020, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0001, 16'd255, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0010, 16'd510, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0100, 16'd765, 1);
    addVec(1, 4'b0010, 32'h0400, 32'h0400, 4'b0010, 8'h04, 8'h04, 4'b1000, 16'd1020, 1);
    addVec(1, 4'b0010, 32'h0400, 32'h0400, 4'b0010, 8'h04, 8'h04, 4'b0000, 16'd0, 1);
    addVec(1, 4'b0010, 32'h0400, 32'h0400, 4'b0010, 8'h04, 8'h04, 4'b0000, 16'd0, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0000, 16'd0, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0010, 16'd16, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0010, 16'd16, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0010, 16'd16, 1);
    addVec(1, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'h00, 4'b0000, 16'd0, 1);

    reset = 1'b1; enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk); @(negedge clk); #1;
    $display("[TB] reset state");
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].valid, tbl[i].a, tbl[i].b);
      checkOutput($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
      checkOutput($sformatf("vec%0d mul_a", i), 64'(mul_a), 64'(tbl[i].exp_ma));
      checkOutput($sformatf("vec%0d mul_b", i), 64'(mul_b), 64'(tbl[i].exp_mb));
      checkOutput($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].exp_rsp));
      checkOutput($sformatf("vec%0d rsp_data", i), 64'(rsp_data), 64'(tbl[i].exp_data));
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].exp_busy));
    end

    // Three back-to-back issues (rr_ptr is 2 here), enable drops with the third.
    $display("[TB] drain sequence");
    applyStimulus(1, 4'b1111, all_a, 32'h02020202);
    checkOutput("drain A ready", 64'(req_ready), 64'b0100);
    applyStimulus(1, 4'b1111, all_a, 32'h02020202);
    checkOutput("drain B ready", 64'(req_ready), 64'b1000);
    applyStimulus(0, 4'b1111, all_a, 32'h02020202);
    checkOutput("drain C ready", 64'(req_ready), 64'b0001);
    t4_rsp  = '{4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    t4_data = '{16'd0, 16'd6, 16'd8, 16'd2, 16'd0};
    t4_busy = '{1, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 4'b1111, all_a, 32'h02020202);
      checkOutput($sformatf("drain +%0d ready", k+1), 64'(req_ready), 64'h0);
      checkOutput($sformatf("drain +%0d rsp_valid", k+1), 64'(rsp_valid), 64'(t4_rsp[k]));
      checkOutput($sformatf("drain +%0d rsp_data", k+1), 64'(rsp_data), 64'(t4_data[k]));
      checkOutput($sformatf("drain +%0d busy", k+1), 64'(busy), 64'(t4_busy[k]));
    end

    // Reset two cycles after an accept: its result must never appear.
    $display("[TB] reset mid-operation");
    applyStimulus(1, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1, 4'b0010, 32'h0700, 32'h0700);
    checkOutput("midreset accept ready", 64'(req_ready), 64'b0010);
    applyStimulus(1, 4'b0000, 32'h0, 32'h0);
    checkOutput("midreset +1 rsp_valid", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 4'b0000, 32'h0, 32'h0);
      checkOutput($sformatf("post-reset %0d rsp_valid", k), 64'(rsp_valid), 64'h0);
      checkOutput($sformatf("post-reset %0d rsp_data", k), 64'(rsp_data), 64'h0);
    end

    // Five grants to requester 1, then look at the counters.
    $display("[TB] grant counters");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 4'b0010, 32'h0100, 32'h0100);
      checkOutput($sformatf("stats grant %0d ready", k), 64'(req_ready), 64'b0010);
    end
    applyStimulus(1, 4'b0000, 32'h0, 32'h0);
`ifdef MULT_ARB_STATS_EN
    exp_gc = 64'h0000_0000_0005_0000;
`else
    exp_gc = 64'h0;
`endif
    checkOutput("grant_count", grant_count, exp_gc);

    for (int k = 0; k < 6; k++) applyStimulus(0, 4'b0000, 32'h0, 32'h0);
    checkOutput("final busy", 64'(busy), 64'h0);
    checkOutput("final rsp_valid", 64'(rsp_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
